// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches words from instruction memory, holds them in the IR for
// the decoder and updates the PC from BS/PS/zero. Optional fetch timeout: INSTR_FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic [1:0]         bs,
  input  logic               ps,
  input  logic               zero,
  input  logic [ADDR_W-1:0]  br_offset,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err
);

  // Handshakes: imem_ack is honoured only while imem_req is high; exec_done only while
  // instr_valid is high (ISSUE). Both sides hold their data until the accepting edge.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 req_q, req_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    next_pc;
  logic [ADDR_W-1:0]    pc_inc;
  logic [ADDR_W-1:0]    pc_br;

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  // Plain modular adds: a two's-complement offset needs no explicit sign extension here.
  assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign pc_br  = pc_q + br_offset;

  always_comb begin
    next_pc = pc_inc;
    case (bs)
      2'b00:   next_pc = pc_inc;
      2'b01:   next_pc = (zero ^ ps) ? pc_br : pc_inc;
      2'b10:   next_pc = pc_br;
      default: next_pc = jump_addr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    err_d   = 1'b0;
`ifdef INSTR_FETCH_TIMEOUT_EN
    wait_cnt_d = '0;
`endif
    case (state_q)
      S_FETCH: begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
`ifdef INSTR_FETCH_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Give up on this attempt; FETCH re-requests the same pc after a one-cycle gap.
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_ISSUE: begin
        if (exec_done) begin
          valid_d = 1'b0;
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

`ifdef INSTR_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory/executor driver tasks, a PC reference model, and a
// scoreboard monitor that checks every issued instruction against the expected queue.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic [1:0]  bs = '0;
  logic        ps = 1'b0;
  logic        zero = 1'b0;
  logic [7:0]  br_offset = '0;
  logic [7:0]  jump_addr = '0;
  logic [7:0]  pc;
  logic        fetch_err;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .bs(bs), .ps(ps), .zero(zero), .br_offset(br_offset),
    .jump_addr(jump_addr), .pc(pc), .fetch_err(fetch_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [256];
  logic [7:0]  model_pc;
  logic [23:0] exp_q [$];
  logic        prev_valid = 1'b0;
  logic [15:0] held_exp = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference branch rules, in plain integer arithmetic modulo 256.
  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [1:0] b,
                                            input logic p, input logic z,
                                            input logic [7:0] off, input logic [7:0] ja);
    int soff;
    int tgt;
    soff = (off >= 8'd128) ? int'(off) - 256 : int'(off);
    tgt  = int'(cur) + 1;
    if (b == 2'd2 || (b == 2'd1 && p != z)) tgt = int'(cur) + soff;
    if (b == 2'd3) tgt = int'(ja);
    return 8'(((tgt % 256) + 256) % 256);
  endfunction

  task automatic expect_fetch(input logic [7:0] a);
    model_pc = a;
    exp_q.push_back({a, mem[a]});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: unexpected issue instr=%0h pc=%0h", instr, pc);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("issue_pc", {24'd0, pc}, {24'd0, e[23:16]});
          check("issue_instr", {16'd0, instr}, {16'd0, e[15:0]});
          held_exp = e[15:0];
        end
      end else if (instr_valid) begin
        check("instr_hold", {16'd0, instr}, {16'd0, held_exp});
      end
`ifndef INSTR_FETCH_TIMEOUT_EN
      check("no_fetch_err", {31'd0, fetch_err}, 32'd0);
`endif
      prev_valid = instr_valid;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // Drives one complete fetch/execute cycle acting as memory and datapath.
  task automatic run_instr(input int ack_dly, input logic [1:0] b, input logic p,
                           input logic z, input logic [7:0] off, input logic [7:0] ja,
                           input int exec_dly, input bit stray);
    logic [7:0] a;
    wait_req();
    check("fetch_addr", {24'd0, imem_addr}, {24'd0, model_pc});
    a = model_pc;
    repeat (ack_dly) begin
      check("req_stable", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, a});
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem[a];
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    check("valid_up", {31'd0, instr_valid}, 32'd1);
    check("req_drop", {31'd0, imem_req}, 32'd0);
    repeat (exec_dly) begin
      if (stray) imem_ack = 1'($urandom);
      @(negedge clk);
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    bs = b; ps = p; zero = z; br_offset = off; jump_addr = ja;
    expect_fetch(model_next(model_pc, b, p, z, off, ja));
    @(negedge clk);
    exec_done = 1'b0;
    check("pc_update", {24'd0, pc}, {24'd0, model_pc});
    check("valid_down", {31'd0, instr_valid}, 32'd0);
    if (stray) begin
      exec_done = 1'b1;
      bs = 2'b11;
      jump_addr = model_pc ^ 8'h5A;
      @(negedge clk);
      exec_done = 1'b0;
      check("stray_exec_pc", {24'd0, pc}, {24'd0, model_pc});
    end
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    exp_q.delete();
    expect_fetch(8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0020;
    expect_fetch(8'h00);
    repeat (3) @(negedge clk);
    reset_now();

    // Directed branch cases
    run_instr(1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1, 1'b0);
    check("t1_pc", {24'd0, pc}, 32'd1);
    run_instr(0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h03, 0, 1'b0);
    run_instr(0, 2'b01, 1'b0, 1'b1, 8'h05, 8'h00, 0, 1'b0);
    check("t2a_pc", {24'd0, pc}, 32'd8);
    run_instr(0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h03, 0, 1'b0);
    run_instr(0, 2'b01, 1'b0, 1'b0, 8'h05, 8'h00, 0, 1'b0);
    check("t2b_pc", {24'd0, pc}, 32'd4);
    run_instr(0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h03, 0, 1'b0);
    run_instr(0, 2'b01, 1'b1, 1'b0, 8'h05, 8'h00, 0, 1'b0);
    check("t2c_pc", {24'd0, pc}, 32'd8);
    run_instr(0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h04, 0, 1'b0);
    run_instr(2, 2'b10, 1'b0, 1'b0, 8'hFE, 8'h00, 0, 1'b0);
    check("t3a_pc", {24'd0, pc}, 32'd2);
    run_instr(0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h40, 0, 1'b0);
    check("t3b_pc", {24'd0, pc}, 32'h40);
    run_instr(0, 2'b11, 1'b0, 1'b0, 8'h00, 8'hFF, 0, 1'b1);
    run_instr(5, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 2, 1'b0);
    check("t4_wrap_pc", {24'd0, pc}, 32'd0);

    // Randomized program flow
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 6)), 2'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
    end

    // Reset during WAIT, then during ISSUE
    wait_req();
    @(negedge clk);
    reset_now();
    run_instr(0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    wait_req();
    imem_ack = 1'b1;
    imem_rdata = mem[model_pc];
    @(negedge clk);
    imem_ack = 1'b0;
    reset_now();
    run_instr(1, 2'b10, 1'b0, 1'b0, 8'h10, 8'h00, 1, 1'b1);

`ifdef INSTR_FETCH_TIMEOUT_EN
    // No ack for 15 WAIT cycles: one error pulse, one idle cycle, retry at the same address
    wait_req();
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      check("to_req_held", {30'd0, imem_req, fetch_err}, 32'd2);
    end
    @(negedge clk);
    check("to_err_pulse", {30'd0, imem_req, fetch_err}, 32'd1);
    @(negedge clk);
    check("to_retry", {22'd0, imem_req, fetch_err, imem_addr}, {22'd0, 2'b10, model_pc});
    run_instr(2, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
`else
    run_instr(20, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
